// File: rtl/rv32i_decoder.sv
// Combinational RV32I instruction decoder: register numbers, immediate, ALU op,
// operand selects and load/store/branch type codes derived from one word.
module rv32i_decoder (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] ir,
   output logic [4:0]  srcreg1_num,
   output logic [4:0]  srcreg2_num,
   output logic [4:0]  dstreg_num,
   output logic [31:0] imm,
   output logic [3:0]  alucode,
   output logic        using_r2,
   output logic        using_pc,
   output logic        write_reg,
   output logic [2:0]  info_load,
   output logic [1:0]  info_store,
   output logic [2:0]  info_branch
);

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;

   localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_SLT = 4'd2, ALU_SLTU = 4'd3;
   localparam logic [3:0] ALU_XOR = 4'd4, ALU_OR  = 4'd5, ALU_AND = 4'd6, ALU_SLL  = 4'd7;
   localparam logic [3:0] ALU_SRL = 4'd8, ALU_SRA = 4'd9, ALU_UNUSED = 4'd15;

   localparam logic [2:0] BR_JUMP = 3'd7;

   // clk/rst are present only for pipeline uniformity
   logic unused_clk_rst;
   assign unused_clk_rst = clk ^ rst;

   logic [6:0]  opcode;
   logic [2:0]  funct3;
   logic [4:0]  rs1, rs2, rd;
   logic [31:0] i_imm, s_imm, b_imm, u_imm, j_imm;
   logic [2:0]  ld_t, br_t;
   logic [1:0]  st_t;

   assign opcode = ir[6:0];
   assign funct3 = ir[14:12];
   assign rs1    = ir[19:15];
   assign rs2    = ir[24:20];
   assign rd     = ir[11:7];
   assign i_imm  = {{20{ir[31]}}, ir[31:20]};
   assign s_imm  = {{20{ir[31]}}, ir[31:25], ir[11:7]};
   assign b_imm  = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
   assign u_imm  = {ir[31:12], 12'b0};
   assign j_imm  = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};

   // alt = ir[30]; allow_sub distinguishes OP (SUB legal) from OP-IMM
   function automatic logic [3:0] alu_f3(input logic [2:0] f3, input logic alt,
                                         input logic allow_sub);
      case (f3)
         3'b000:  alu_f3 = (alt && allow_sub) ? ALU_SUB : ALU_ADD;
         3'b001:  alu_f3 = ALU_SLL;
         3'b010:  alu_f3 = ALU_SLT;
         3'b011:  alu_f3 = ALU_SLTU;
         3'b100:  alu_f3 = ALU_XOR;
         3'b101:  alu_f3 = alt ? ALU_SRA : ALU_SRL;
         3'b110:  alu_f3 = ALU_OR;
         default: alu_f3 = ALU_AND;
      endcase
   endfunction

   always_comb begin
      ld_t = 3'd0;
      case (funct3)
         3'b000: ld_t = 3'd1;
         3'b001: ld_t = 3'd2;
         3'b010: ld_t = 3'd3;
         3'b100: ld_t = 3'd4;
         3'b101: ld_t = 3'd5;
         default: ld_t = 3'd0;
      endcase
      st_t = 2'd0;
      case (funct3)
         3'b000: st_t = 2'd1;
         3'b001: st_t = 2'd2;
         3'b010: st_t = 2'd3;
         default: st_t = 2'd0;
      endcase
      br_t = 3'd0;
      case (funct3)
         3'b000: br_t = 3'd1;
         3'b001: br_t = 3'd2;
         3'b100: br_t = 3'd3;
         3'b101: br_t = 3'd4;
         3'b110: br_t = 3'd5;
         3'b111: br_t = 3'd6;
         default: br_t = 3'd0;
      endcase
   end

   always_comb begin
      srcreg1_num = 5'd0;
      srcreg2_num = 5'd0;
      dstreg_num  = 5'd0;
      imm         = 32'd0;
      alucode     = ALU_UNUSED;
      using_r2    = 1'b0;
      using_pc    = 1'b0;
      write_reg   = 1'b0;
      info_load   = 3'd0;
      info_store  = 2'd0;
      info_branch = 3'd0;
      case (opcode)
         OPC_OP: begin
            srcreg1_num = rs1;
            srcreg2_num = rs2;
            dstreg_num  = rd;
            alucode     = alu_f3(funct3, ir[30], 1'b1);
            using_r2    = 1'b1;
            write_reg   = 1'b1;
         end
         OPC_OP_IMM: begin
            srcreg1_num = rs1;
            dstreg_num  = rd;
            imm         = (funct3 == 3'b001 || funct3 == 3'b101) ? {27'd0, ir[24:20]} : i_imm;
            alucode     = alu_f3(funct3, ir[30], 1'b0);
            write_reg   = 1'b1;
         end
         OPC_LUI, OPC_AUIPC: begin
            dstreg_num = rd;
            imm        = u_imm;
            alucode    = (opcode == OPC_AUIPC) ? ALU_ADD : ALU_UNUSED;
            using_pc   = (opcode == OPC_AUIPC);
            write_reg  = 1'b1;
         end
         OPC_LOAD: if (ld_t != 3'd0) begin
            srcreg1_num = rs1;
            dstreg_num  = rd;
            imm         = i_imm;
            alucode     = ALU_ADD;
            write_reg   = 1'b1;
            info_load   = ld_t;
         end
         OPC_STORE: if (st_t != 2'd0) begin
            srcreg1_num = rs1;
            srcreg2_num = rs2;
            imm         = s_imm;
            alucode     = ALU_ADD;
            info_store  = st_t;
         end
         OPC_BRANCH: if (br_t != 3'd0) begin
            srcreg1_num = rs1;
            srcreg2_num = rs2;
            imm         = b_imm;
            alucode     = ALU_ADD;
            using_pc    = 1'b1;
            info_branch = br_t;
         end
         OPC_JAL: begin
            dstreg_num  = rd;
            imm         = j_imm;
            alucode     = ALU_ADD;
            using_pc    = 1'b1;
            write_reg   = 1'b1;
            info_branch = BR_JUMP;
         end
         // JALR with nonzero funct3 falls through to the illegal default
         OPC_JALR: if (funct3 == 3'b000) begin
            srcreg1_num = rs1;
            dstreg_num  = rd;
            imm         = i_imm;
            alucode     = ALU_ADD;
            write_reg   = 1'b1;
            info_branch = BR_JUMP;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_rv32i_decoder.sv
// Table-driven scoreboard bench for rv32i_decoder; expected records are queued
// when an instruction is driven and compared on the following falling edge.
module tb_rv32i_decoder;

   logic        clk, rst;
   logic [31:0] ir;
   logic [4:0]  srcreg1_num, srcreg2_num, dstreg_num;
   logic [31:0] imm;
   logic [3:0]  alucode;
   logic        using_r2, using_pc, write_reg;
   logic [2:0]  info_load;
   logic [1:0]  info_store;
   logic [2:0]  info_branch;

   rv32i_decoder dut (
      .clk(clk), .rst(rst), .ir(ir),
      .srcreg1_num(srcreg1_num), .srcreg2_num(srcreg2_num), .dstreg_num(dstreg_num),
      .imm(imm), .alucode(alucode), .using_r2(using_r2), .using_pc(using_pc),
      .write_reg(write_reg), .info_load(info_load), .info_store(info_store),
      .info_branch(info_branch)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [4:0]  s1, s2, d;
      logic [31:0] imm;
      logic [3:0]  alu;
      logic        r2, pc, wr;
      logic [2:0]  ld;
      logic [1:0]  st;
      logic [2:0]  br;
   } out_t;

   typedef struct {
      string       name;
      logic [31:0] ir;
      out_t        exp;
   } vec_t;

   typedef struct {
      string name;
      out_t  exp;
   } sb_t;

   vec_t vecs[$];
   sb_t  sbq[$];
   int   checks = 0;
   int   errors = 0;

   function automatic out_t mk(input logic [4:0] s1, input logic [4:0] s2, input logic [4:0] d,
                               input logic [31:0] im, input logic [3:0] alu, input logic r2,
                               input logic pc, input logic wr, input logic [2:0] ld,
                               input logic [1:0] st, input logic [2:0] br);
      out_t o;
      o.s1 = s1; o.s2 = s2; o.d = d; o.imm = im; o.alu = alu;
      o.r2 = r2; o.pc = pc; o.wr = wr; o.ld = ld; o.st = st; o.br = br;
      return o;
   endfunction

   task automatic add(input string n, input logic [31:0] w, input out_t e);
      vec_t v;
      v.name = n; v.ir = w; v.exp = e;
      vecs.push_back(v);
   endtask

   function automatic out_t actual();
      return mk(srcreg1_num, srcreg2_num, dstreg_num, imm, alucode, using_r2, using_pc,
                write_reg, info_load, info_store, info_branch);
   endfunction

   task automatic drive(input string n, input logic [31:0] w, input out_t e);
      sb_t s;
      ir = w;
      s.name = n; s.exp = e;
      sbq.push_back(s);
   endtask

   task automatic check_out();
      sb_t  s;
      out_t a;
      if (sbq.size() == 0) begin
         checks++; errors++;
         $display("FAIL scoreboard_empty: no expected record queued");
         return;
      end
      s = sbq.pop_front();
      a = actual();
      checks++;
      if (a !== s.exp) begin
         errors++;
         $display("FAIL %s: got s1=%0d s2=%0d d=%0d imm=%h alu=%0d r2=%b pc=%b wr=%b ld=%0d st=%0d br=%0d want s1=%0d s2=%0d d=%0d imm=%h alu=%0d r2=%b pc=%b wr=%b ld=%0d st=%0d br=%0d",
                  s.name, a.s1, a.s2, a.d, a.imm, a.alu, a.r2, a.pc, a.wr, a.ld, a.st, a.br,
                  s.exp.s1, s.exp.s2, s.exp.d, s.exp.imm, s.exp.alu, s.exp.r2, s.exp.pc,
                  s.exp.wr, s.exp.ld, s.exp.st, s.exp.br);
      end
   endtask

   initial begin
      //            name          ir            s1  s2  d   imm           alu r2 pc wr ld st br
      add("add",    32'h00B50633, mk(10, 11, 12, 32'h00000000, 0,  1, 0, 1, 0, 0, 0));
      add("sub",    32'h40B60633, mk(12, 11, 12, 32'h00000000, 1,  1, 0, 1, 0, 0, 0));
      add("sra",    32'h40B5D7B3, mk(11, 11, 15, 32'h00000000, 9,  1, 0, 1, 0, 0, 0));
      add("or",     32'h00B56633, mk(10, 11, 12, 32'h00000000, 5,  1, 0, 1, 0, 0, 0));
      add("addi",   32'hFFF00513, mk(0,  0,  10, 32'hFFFFFFFF, 0,  0, 0, 1, 0, 0, 0));
      add("srai",   32'h4015D793, mk(11, 0,  15, 32'h00000001, 9,  0, 0, 1, 0, 0, 0));
      add("sltiu",  32'hFFF5B693, mk(11, 0,  13, 32'hFFFFFFFF, 3,  0, 0, 1, 0, 0, 0));
      add("lui",    32'h808805B7, mk(0,  0,  11, 32'h80880000, 15, 0, 0, 1, 0, 0, 0));
      add("auipc",  32'h00000817, mk(0,  0,  16, 32'h00000000, 0,  0, 1, 1, 0, 0, 0));
      add("sh",     32'h00B510A3, mk(10, 11, 0,  32'h00000001, 0,  0, 0, 0, 0, 2, 0));
      add("lbu",    32'h00354683, mk(10, 0,  13, 32'h00000003, 0,  0, 0, 1, 4, 0, 0));
      add("beq",    32'hFEC584E3, mk(11, 12, 0,  32'hFFFFFFE8, 0,  0, 1, 0, 0, 0, 1));
      add("bgeu",   32'hF8E572E3, mk(10, 14, 0,  32'hFFFFFF84, 0,  0, 1, 0, 0, 0, 6));
      add("jal",    32'h00C0006F, mk(0,  0,  0,  32'h0000000C, 0,  0, 1, 1, 0, 0, 7));
      add("jalr",   32'h00C08067, mk(1,  0,  0,  32'h0000000C, 0,  0, 0, 1, 0, 0, 7));
      add("fence",  32'h0000000F, mk(0,  0,  0,  32'h00000000, 15, 0, 0, 0, 0, 0, 0));
      add("badopc", 32'hFFFFFFFF, mk(0,  0,  0,  32'h00000000, 15, 0, 0, 0, 0, 0, 0));
      add("ld_f3",  32'h00353683, mk(0,  0,  0,  32'h00000000, 15, 0, 0, 0, 0, 0, 0));
      add("zero",   32'h00000000, mk(0,  0,  0,  32'h00000000, 15, 0, 0, 0, 0, 0, 0));

      // outputs follow ir even while reset is held
      rst = 1'b1;
      ir  = 32'h0;
      @(posedge clk); #1;
      drive("in_reset_add", vecs[0].ir, vecs[0].exp);
      @(negedge clk); check_out();
      @(posedge clk); #1;
      rst = 1'b0;

      foreach (vecs[i]) begin
         drive(vecs[i].name, vecs[i].ir, vecs[i].exp);
         @(negedge clk); check_out();
         @(posedge clk); #1;
      end

      // a reset pulse with ir held constant must not disturb the decode
      drive("pre_rst_beq", vecs[11].ir, vecs[11].exp);
      @(negedge clk); check_out();
      rst = 1'b1;
      @(posedge clk); #1;
      sbq.push_back('{name: "rst_beq", exp: vecs[11].exp});
      @(negedge clk); check_out();
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      sbq.push_back('{name: "post_rst_beq", exp: vecs[11].exp});
      @(negedge clk); check_out();

      // back-to-back change within one cycle settles combinationally
      drive("lui_fast", vecs[7].ir, vecs[7].exp);
      #1;
      check_out();
      drive("sb_fast", 32'h00B50023, mk(10, 11, 0, 32'h00000000, 0, 0, 0, 0, 0, 1, 0));
      #1;
      check_out();

      if (sbq.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_leftover: got %0d pending want 0", sbq.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/rv32i_decoder.md
Name: rv32i_decoder

Overview:
- Combinational RV32I instruction decoder in the execute front-end.
- Takes one 32-bit instruction word and produces:
  - register numbers
  - a sign-extended immediate
  - the ALU operation
  - operand-select flags
  - writeback enable
  - load, store and branch type codes
- The clock and reset exist for pipeline uniformity. The decode path itself holds no state.

Parameters:
- None.

Ports:
- clk  input  1  system clock; has no effect on decode outputs
- rst  input  1  synchronous active-high reset; has no effect on decode outputs
- ir  input  32  instruction word
- srcreg1_num  output  5  rs1 number
- srcreg2_num  output  5  rs2 number
- dstreg_num  output  5  rd number
- imm  output  32  decoded immediate, sign- or zero-extended
- alucode  output  4  ALU operation
- using_r2  output  1  ALU operand B = rs2 (1) or imm (0)
- using_pc  output  1  ALU operand A = PC (1) or rs1 (0)
- write_reg  output  1  rd writeback enable
- info_load  output  3  load type
- info_store  output  2  store type
- info_branch  output  3  branch/jump type

Behaviour:
- Global rules:
  - Pure combinational function of ir. Outputs settle within the same cycle.
  - There is no reset value: rst and clk do not alter outputs.
  - Any field an instruction does not use is driven to 0.
- Codes (99_define.v):
  - TRUE=1, FALSE=0.
  - alucode: ADD=0, SUB=1, SLT=2, SLTu=3, XOR=4, OR=5, AND=6, SLL=7, SRL=8, SRA=9, UNUSED=15.
  - info_load: NOTLOAD=0, Lb=1, Lh=2, Lw=3, Lbu=4, Lhu=5.
  - info_store: NOTSTORE=0, Sb=1, Sh=2, Sw=3.
  - info_branch: NOTBRANCH=0, Beq=1, Bne=2, Blt=3, Bge=4, Bltu=5, Bgeu=6, BJAL=7, BJALR=7.
  - JAL and JALR share code 7. They are distinguished by using_pc.
- OP (0110011), R-type:
  - src1=ir[19:15], src2=ir[24:20], dst=ir[11:7], imm=0.
  - using_r2=1, using_pc=0, write_reg=1.
  - funct3 maps 000→ADD (SUB if ir[30]), 001→SLL, 010→SLT, 011→SLTu, 100→XOR, 101→SRL (SRA if ir[30]), 110→OR, 111→AND.
- OP-IMM (0010011):
  - src1=rs1, src2=0, dst=rd, using_r2=0, write_reg=1.
  - imm = sign-extended ir[31:20].
  - For shifts (funct3 001/101): imm = zero-extended ir[24:20]; ir[30] selects SRA vs SRL.
  - funct3 map as for OP; there is no SUB.
- LUI (0110111):
  - src1=src2=0, dst=rd, imm={ir[31:12],12'b0}.
  - alucode=UNUSED, using_pc=0, write_reg=1.
- AUIPC (0010111):
  - As LUI, except alucode=ADD and using_pc=1.
- LOAD (0000011):
  - src1=rs1, src2=0, dst=rd, imm = sign-extended I-immediate.
  - alucode=ADD, write_reg=1.
  - funct3 000/001/010/100/101 → Lb/Lh/Lw/Lbu/Lhu.
- STORE (0100011):
  - src1=rs1, src2=rs2, dst=0.
  - imm = sign-extended {ir[31:25],ir[11:7]}.
  - alucode=ADD, using_r2=0, write_reg=0.
  - funct3 000/001/010 → Sb/Sh/Sw.
- BRANCH (1100011):
  - src1=rs1, src2=rs2, dst=0.
  - imm = sign-extended {ir[31],ir[7],ir[30:25],ir[11:8],0}.
  - alucode=ADD, using_r2=0, using_pc=1, write_reg=0.
  - funct3 000/001/100/101/110/111 → Beq/Bne/Blt/Bge/Bltu/Bgeu.
- JAL (1101111):
  - src1=src2=0, dst=rd.
  - imm = sign-extended {ir[31],ir[19:12],ir[20],ir[30:21],0}.
  - alucode=ADD, using_pc=1, write_reg=1 (also when rd=0), info_branch=BJAL.
- JALR (1100111):
  - src1=rs1, src2=0, dst=rd, imm = sign-extended I-immediate.
  - alucode=ADD, using_pc=0, write_reg=1, info_branch=BJALR.
- Unknown opcodes, undefined funct3 and FENCE/SYSTEM:
  - All outputs 0, except alucode=UNUSED.
  - write_reg=0, NOTLOAD, NOTSTORE, NOTBRANCH.

Test Plan:
- R-type:
  - ir=0x00B50633 → ADD, src 10/11, dst 12, using_r2=1, write_reg=1.
  - 0x40B60633 → SUB.
  - 0x40B5D7B3 → SRA, src 11/11, dst 15.
- I-type:
  - 0xFFF00513 → ADD, src1 0, dst 10, imm 0xFFFFFFFF, using_r2=0.
  - 0x4015D793 → SRA, imm 1.
  - 0xFFF5B693 → SLTu, imm 0xFFFFFFFF.
- Upper-immediate:
  - 0x808805B7 → dst 11, imm 0x80880000, alucode UNUSED.
  - 0x00000817 → dst 16, imm 0, ADD, using_pc=1.
- Memory:
  - 0x00B510A3 → Sh, src 10/11, dst 0, imm 1, write_reg=0.
  - 0x00354683 → Lbu, src1 10, dst 13, imm 3, write_reg=1.
- Branch:
  - 0xFEC584E3 → Beq, src 11/12, imm -24, using_pc=1, write_reg=0.
  - 0xF8E572E3 → Bgeu, imm -124.
- Jumps:
  - 0x00C0006F → BJAL, dst 0, imm 12, using_pc=1, write_reg=1.
  - 0x00C08067 → BJALR, src1 1, imm 12, using_pc=0.
  - 0x0000000F (FENCE) → write_reg=0, all info codes 0.
